// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding, the default width and the counter-width helper.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit count of the step counter; it only has to reach width-1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor: diff = a - b - bin, with borrow-out.
// Subtracting counterpart of full_adder.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing diff = a - b - bin LSB first, one bit per clock.
// Optional signed-overflow output ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sh_reg;
  logic [WIDTH-1:0] sh_next;
  logic [WIDTH-1:0] diff_reg;
  logic [CW-1:0]    cnt_reg;
  logic             brw_reg;
  logic             bout_reg;
  logic             bit_d;
  logic             bit_bo;
  logic             accept;
  logic             last_step;

  full_subtractor u_fs (
    .a   (a_reg[0]),
    .b   (b_reg[0]),
    .bin (brw_reg),
    .diff(bit_d),
    .bout(bit_bo)
  );

  // A new operation may start from IDLE or straight out of DONE.
  assign accept    = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_step = (cnt_reg == CW'(WIDTH - 1));
  assign sh_next   = {bit_d, sh_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  // Datapath: operand shift registers, borrow flop, step counter, result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sh_reg   <= '0;
      diff_reg <= '0;
      cnt_reg  <= '0;
      brw_reg  <= 1'b0;
      bout_reg <= 1'b0;
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= b;
      brw_reg <= bin;
      cnt_reg <= '0;
      sh_reg  <= '0;
    end else if (state_reg == RUN) begin
      sh_reg  <= sh_next;
      a_reg   <= {1'b0, a_reg[WIDTH-1:1]};
      b_reg   <= {1'b0, b_reg[WIDTH-1:1]};
      brw_reg <= bit_bo;
      cnt_reg <= cnt_reg + CW'(1);
      if (last_step) begin
        diff_reg <= sh_next;
        bout_reg <= bit_bo;
      end
    end
  end

  assign diff = diff_reg;
  assign bout = bout_reg;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_reg;

  // On the final step a_reg[0]/b_reg[0] hold the operand sign bits and bit_d is the result sign.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (!accept && (state_reg == RUN) && last_step) begin
      ovf_reg <= (a_reg[0] ^ b_reg[0]) & (a_reg[0] ^ bit_d);
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vector table,
// back-to-back / reset corner sequences and a sampled random sweep.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Wait for done after the accepting edge; cycles counts edges from that edge.
  task automatic wait_done(output int cycles, output int busy_cyc);
    cycles   = 0;
    busy_cyc = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_cyc++;
      tick();
      cycles++;
    end
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        output int cycles, output int busy_cyc);
    a     = av;
    b     = bv;
    bin   = bi;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cycles, busy_cyc);
    $display("op a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d cycles=%0d", av, bv, bi, diff, bout, cycles);
  endtask

  vec_t vecs[12];

  initial begin
    int cyc;
    int bcyc;
    int seen;
    logic [8:0] r9;
    int s;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rbi;
    logic       exp_ov;

    vecs[0]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5]  = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{8'h0A, 8'h02, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[7]  = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[8]  = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[9]  = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
    vecs[11] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};

    // Reset state
    repeat (3) tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    chk("reset_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("reset_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, cyc, bcyc);
      chk("latency", 32'(cyc), 32'd8);
      chk("busy_cycles", 32'(bcyc), 32'd8);
      chk("vec_diff", 32'(diff), 32'(vecs[i].d));
      chk("vec_bout", 32'(bout), 32'(vecs[i].bo));
`ifdef SERIAL_SUB_OVF_EN
      chk("vec_ovf", 32'(ovf), 32'(vecs[i].ov));
`endif
      tick();
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_not_busy", 32'(busy), 32'd0);
      chk("diff_held", 32'(diff), 32'(vecs[i].d));
    end

    // Back-to-back with start held high; operand changes during RUN are ignored
    a     = 8'h10;
    b     = 8'h01;
    bin   = 1'b0;
    start = 1'b1;
    tick();
    a = 8'hFF;
    b = 8'hFF;
    wait_done(cyc, bcyc);
    $display("op a=10 b=01 bin=0 (start held) -> diff=%02h bout=%0d cycles=%0d", diff, bout, cyc);
    chk("b2b_latency1", 32'(cyc), 32'd8);
    chk("b2b_diff1", 32'(diff), 32'h0F);
    chk("b2b_bout1", 32'(bout), 32'd0);
    tick();
    chk("b2b_accept_busy", 32'(busy), 32'd1);
    chk("b2b_accept_done", 32'(done), 32'd0);
    start = 1'b0;
    tick();
    tick();
    chk("b2b_diff_stable_in_run", 32'(diff), 32'h0F);
    wait_done(cyc, bcyc);
    $display("op a=ff b=ff bin=0 (accepted in DONE) -> diff=%02h bout=%0d", diff, bout);
    chk("b2b_latency2", 32'(cyc + 2), 32'd8);
    chk("b2b_diff2", 32'(diff), 32'h00);
    chk("b2b_bout2", 32'(bout), 32'd0);
    tick();

    // Reset in the middle of RUN discards the partial result
    run_op(8'h03, 8'h05, 1'b0, cyc, bcyc);
    chk("pre_reset_diff", 32'(diff), 32'hFE);
    tick();
    a     = 8'h33;
    b     = 8'h11;
    bin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    $display("op reset mid-run -> busy=%0d done=%0d diff=%02h bout=%0d", busy, done, diff, bout);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_bout", 32'(bout), 32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) seen = 1;
    end
    chk("midrst_stays_idle", 32'(seen), 32'd0);
    run_op(8'h0A, 8'h02, 1'b0, cyc, bcyc);
    chk("post_rst_latency", 32'(cyc), 32'd8);
    chk("post_rst_diff", 32'(diff), 32'h08);
    chk("post_rst_bout", 32'(bout), 32'd0);
    tick();

    // Sampled random sweep against an arithmetic reference
    for (int n = 0; n < 150; n++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rbi = 1'($urandom_range(0, 1));
      r9  = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
      s   = int'($signed(ra)) - int'($signed(rb)) - int'(rbi);
      exp_ov = (s > 127) || (s < -128);
      run_op(ra, rb, rbi, cyc, bcyc);
      chk("rnd_latency", 32'(cyc), 32'd8);
      chk("rnd_diff", 32'(diff), 32'(r9[7:0]));
      chk("rnd_bout", 32'(bout), 32'(r9[8]));
`ifdef SERIAL_SUB_OVF_EN
      chk("rnd_ovf", 32'(ovf), 32'(exp_ov));
`else
      if (exp_ov) seen = 0;
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
